// File: rtl/imm_gen_pipe.sv
// Two-stage RV32/RV64 immediate generator with valid/ready handshakes on both sides.
// Define IMM_GEN_CSR_EN to decode CSR-immediate (funct3 101/110/111) as the Z format.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag,
   output logic [15:0]      illegal_cnt
);

   localparam logic [2:0] FMT_NONE  = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_S     = 3'd2;
   localparam logic [2:0] FMT_B     = 3'd3;
   localparam logic [2:0] FMT_U     = 3'd4;
   localparam logic [2:0] FMT_J     = 3'd5;
   localparam logic [2:0] FMT_SHAMT = 3'd6;
   localparam logic [2:0] FMT_Z     = 3'd7;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMW = 7'b0011011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   function automatic logic [2:0] decode_fmt(input logic [31:0] inst);
      logic [2:0] f3;
      logic       is_sh;
      logic [2:0] fmt;
      f3    = inst[14:12];
      is_sh = (f3 == 3'b001) || (f3 == 3'b101);
      fmt   = FMT_NONE;
      case (inst[6:0])
         OPC_LOAD:   if (XLEN == 64 || (f3 != 3'b011 && f3 != 3'b110)) fmt = FMT_I;
         OPC_JALR:   fmt = FMT_I;
         OPC_OP_IMM: fmt = is_sh ? FMT_SHAMT : FMT_I;
         OPC_OP_IMW: if (XLEN == 64) fmt = is_sh ? FMT_SHAMT : FMT_I;
         OPC_STORE:  fmt = FMT_S;
         OPC_BRANCH: fmt = FMT_B;
         OPC_LUI,
         OPC_AUIPC:  fmt = FMT_U;
         OPC_JAL:    fmt = FMT_J;
`ifdef IMM_GEN_CSR_EN
         OPC_SYSTEM: if (f3 == 3'b101 || f3 == 3'b110 || f3 == 3'b111) fmt = FMT_Z;
`else
         OPC_SYSTEM: fmt = FMT_NONE;
`endif
         default:    fmt = FMT_NONE;
      endcase
      return fmt;
   endfunction

   // RV64 OP-IMM shifts carry a 6-bit shamt; the W-forms and RV32 keep 5 bits.
   function automatic logic [XLEN-1:0] build_imm(input logic [31:0] inst, input logic [2:0] fmt);
      logic [XLEN-1:0] imm;
      imm = '0;
      case (fmt)
         FMT_I:     imm = {{(XLEN-11){inst[31]}}, inst[30:20]};
         FMT_S:     imm = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
         FMT_B:     imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
         FMT_U:     imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
         FMT_J:     imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
         FMT_SHAMT: begin
            if (XLEN == 64 && inst[6:0] == OPC_OP_IMM)
               imm = {{(XLEN-6){1'b0}}, inst[25:20]};
            else
               imm = {{(XLEN-5){1'b0}}, inst[24:20]};
         end
         FMT_Z:     imm = {{(XLEN-5){1'b0}}, inst[19:15]};
         default:   imm = '0;
      endcase
      return imm;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
      return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
   endfunction

   logic                vld_p1;
   logic [31:0]         inst_p1;
   logic [TAG_W-1:0]    tag_p1;
   logic [2:0]          fmt_p1;

   logic                vld_p2;
   logic [XLEN-1:0]     imm_p2;
   logic [2:0]          fmt_p2;
   logic                ill_p2;
   logic [TAG_W-1:0]    tag_p2;

   logic [15:0]         ill_cnt;
   logic                adv_p1;
   logic                adv_p2;
   logic                take_in;
   logic                take_out;

   assign adv_p2   = !vld_p2 || out_ready;
   assign adv_p1   = !vld_p1 || adv_p2;
   assign in_ready = !rst && adv_p1;
   assign take_in  = in_valid && in_ready && !flush;
   assign take_out = vld_p2 && out_ready;

   // Stage 1: capture instruction, tag and decoded format
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else if (flush) begin
         vld_p1 <= 1'b0;
      end else if (adv_p1) begin
         vld_p1 <= in_valid;
      end
      if (take_in) begin
         inst_p1 <= in_inst;
         tag_p1  <= in_tag;
         fmt_p1  <= decode_fmt(in_inst);
      end
   end

   // Stage 2: assembled immediate presented to the consumer
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2 <= 1'b0;
         imm_p2 <= '0;
         fmt_p2 <= FMT_NONE;
         ill_p2 <= 1'b0;
         tag_p2 <= '0;
      end else begin
         if (flush) begin
            vld_p2 <= 1'b0;
         end else if (adv_p2) begin
            vld_p2 <= vld_p1;
         end
         if (!flush && adv_p2 && vld_p1) begin
            imm_p2 <= build_imm(inst_p1, fmt_p1);
            fmt_p2 <= fmt_p1;
            ill_p2 <= (fmt_p1 == FMT_NONE);
            tag_p2 <= tag_p1;
         end
      end
   end

   // A flushed entry is discarded even if the consumer was ready, so it is not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ill_cnt <= 16'd0;
      end else if (take_out && ill_p2 && !flush) begin
         ill_cnt <= sat_inc(ill_cnt);
      end
   end

   assign out_valid   = vld_p2;
   assign out_imm     = imm_p2;
   assign out_fmt     = fmt_p2;
   assign out_illegal = ill_p2;
   assign out_tag     = tag_p2;
   assign illegal_cnt = ill_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomized bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and
// are scored against a queue-based reference model of the immediate rules.
module tb_imm_gen_pipe;
   localparam int TAG_W = 4;
`ifdef IMM_GEN_CSR_EN
   localparam bit CSR_EN = 1'b1;
`else
   localparam bit CSR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst, flush, in_valid, out_ready;
   logic [31:0]      in_inst;
   logic [TAG_W-1:0] in_tag;

   logic             in_ready_a, out_valid_a, out_illegal_a;
   logic [31:0]      out_imm_a;
   logic [2:0]       out_fmt_a;
   logic [TAG_W-1:0] out_tag_a;
   logic [15:0]      cnt_a;

   logic             in_ready_b, out_valid_b, out_illegal_b;
   logic [63:0]      out_imm_b;
   logic [2:0]       out_fmt_b;
   logic [TAG_W-1:0] out_tag_b;
   logic [15:0]      cnt_b;

   imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) u_dut32 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_illegal(out_illegal_a),
      .out_tag(out_tag_a), .illegal_cnt(cnt_a)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) u_dut64 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_inst(in_inst), .in_tag(in_tag), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_illegal(out_illegal_b),
      .out_tag(out_tag_b), .illegal_cnt(cnt_b)
   );

   typedef struct {
      logic [TAG_W-1:0] tag;
      longint           acc;
      logic [31:0]      imm32;
      logic [63:0]      imm64;
      logic [2:0]       fmt32;
      logic [2:0]       fmt64;
   } exp_t;

   exp_t        q[$];
   int          nvec = 0;
   int          nerr = 0;
   longint      edges = 0;
   int          cnt32 = 0;
   int          cnt64 = 0;
   bit          accepted;
   bit          ovr32 = 1'b0, ovr64 = 1'b0;
   logic [31:0] o_imm32;
   logic [63:0] o_imm64;
   logic [2:0]  o_fmt32, o_fmt64;

   function automatic logic [2:0] ref_fmt(input logic [31:0] inst, input bit rv64);
      logic [6:0] opc;
      logic [2:0] f3;
      bit         sh;
      opc = inst[6:0];
      f3  = inst[14:12];
      sh  = (f3 == 3'd1) || (f3 == 3'd5);
      if (opc == 7'h03) return (!rv64 && (f3 == 3'd3 || f3 == 3'd6)) ? 3'd0 : 3'd1;
      if (opc == 7'h67) return 3'd1;
      if (opc == 7'h13) return sh ? 3'd6 : 3'd1;
      if (opc == 7'h1B) return !rv64 ? 3'd0 : (sh ? 3'd6 : 3'd1);
      if (opc == 7'h23) return 3'd2;
      if (opc == 7'h63) return 3'd3;
      if (opc == 7'h37 || opc == 7'h17) return 3'd4;
      if (opc == 7'h6F) return 3'd5;
      if (opc == 7'h73 && CSR_EN && f3 >= 3'd5) return 3'd7;
      return 3'd0;
   endfunction

   // Arithmetic-shift formulation of each immediate, 64 bits wide; 32-bit results are the low half.
   function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] fmt, input bit rv64);
      longint s, r;
      s = longint'($signed(inst));
      case (fmt)
         3'd1: r = s >>> 20;
         3'd2: r = ((s >>> 25) << 5) | longint'(inst[11:7]);
         3'd3: r = ((s >>> 31) << 12) | (longint'(inst[7]) << 11) | (longint'(inst[30:25]) << 5)
                   | (longint'(inst[11:8]) << 1);
         3'd4: r = (s >>> 12) << 12;
         3'd5: r = ((s >>> 31) << 20) | (longint'(inst[19:12]) << 12) | (longint'(inst[20]) << 11)
                   | (longint'(inst[30:21]) << 1);
         3'd6: r = (rv64 && inst[6:0] == 7'h13) ? longint'(inst[25:20]) : longint'(inst[24:20]);
         3'd7: r = longint'(inst[19:15]);
         default: r = 0;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] rand_inst();
      logic [6:0]  opcs [13] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37,
                                 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F, 7'h00};
      logic [31:0] r;
      r = $urandom();
      if ($urandom_range(9, 0) != 0) r[6:0] = opcs[$urandom_range(12, 0)];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edges);
      end
   endtask

   task automatic observe();
      bit          exp_ir, exp_ov;
      logic [63:0] r;
      exp_t        e;
      exp_ir = !(q.size() >= 2 && !out_ready);
      exp_ov = (q.size() > 0) && (edges >= q[0].acc + 1);
      chk("in_ready32", 64'(in_ready_a), 64'(exp_ir));
      chk("in_ready64", 64'(in_ready_b), 64'(exp_ir));
      chk("out_valid32", 64'(out_valid_a), 64'(exp_ov));
      chk("out_valid64", 64'(out_valid_b), 64'(exp_ov));
      chk("ill_cnt32", 64'(cnt_a), 64'(cnt32));
      chk("ill_cnt64", 64'(cnt_b), 64'(cnt64));
      if (exp_ov) begin
         e = q[0];
         chk("imm32", 64'(out_imm_a), 64'(e.imm32));
         chk("fmt32", 64'(out_fmt_a), 64'(e.fmt32));
         chk("ill32", 64'(out_illegal_a), 64'(e.fmt32 == 3'd0));
         chk("tag32", 64'(out_tag_a), 64'(e.tag));
         chk("imm64", out_imm_b, e.imm64);
         chk("fmt64", 64'(out_fmt_b), 64'(e.fmt64));
         chk("ill64", 64'(out_illegal_b), 64'(e.fmt64 == 3'd0));
         chk("tag64", 64'(out_tag_b), 64'(e.tag));
      end
      accepted = 1'b0;
      if (flush) begin
         q.delete();
      end else begin
         if (exp_ov && out_ready) begin
            if (q[0].fmt32 == 3'd0 && cnt32 < 65535) cnt32++;
            if (q[0].fmt64 == 3'd0 && cnt64 < 65535) cnt64++;
            void'(q.pop_front());
         end
         if (in_valid && exp_ir) begin
            e.tag   = in_tag;
            e.acc   = edges + 1;
            e.fmt32 = ref_fmt(in_inst, 1'b0);
            r       = ref_imm(in_inst, e.fmt32, 1'b0);
            e.imm32 = r[31:0];
            e.fmt64 = ref_fmt(in_inst, 1'b1);
            e.imm64 = ref_imm(in_inst, e.fmt64, 1'b1);
            if (ovr32) begin e.imm32 = o_imm32; e.fmt32 = o_fmt32; end
            if (ovr64) begin e.imm64 = o_imm64; e.fmt64 = o_fmt64; end
            q.push_back(e);
            accepted = 1'b1;
         end
      end
   endtask

   task automatic cycle(input bit v, input logic [31:0] inst, input logic [TAG_W-1:0] tag,
                        input bit ordy, input bit fl);
      in_valid  = v;
      in_inst   = inst;
      in_tag    = tag;
      out_ready = ordy;
      flush     = fl;
      #1;
      observe();
      @(posedge clk);
      edges++;
      #1;
   endtask

   task automatic drain();
      repeat (4) cycle(1'b0, 32'h0, '0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b1; in_inst = 32'h0; in_tag = '1; out_ready = 1'b1; flush = 1'b0;
      #1;
      chk("rst_in_ready32", 64'(in_ready_a), 64'd0);
      repeat (2) begin
         @(posedge clk);
         edges++;
         #1;
         chk("rst_in_ready64", 64'(in_ready_b), 64'd0);
      end
      chk("rst_out_valid32", 64'(out_valid_a), 64'd0);
      chk("rst_out_valid64", 64'(out_valid_b), 64'd0);
      chk("rst_imm32", 64'(out_imm_a), 64'd0);
      chk("rst_imm64", out_imm_b, 64'd0);
      chk("rst_fmt", 64'(out_fmt_a), 64'd0);
      chk("rst_ill", 64'(out_illegal_a), 64'd0);
      chk("rst_tag", 64'(out_tag_b), 64'd0);
      chk("rst_cnt32", 64'(cnt_a), 64'd0);
      chk("rst_cnt64", 64'(cnt_b), 64'd0);
      q.delete();
      cnt32 = 0;
      cnt64 = 0;
      rst = 1'b0;
   endtask

   task automatic send_dir(input logic [31:0] inst, input bit e32, input logic [31:0] i32,
                           input logic [2:0] f32, input bit e64, input logic [63:0] i64,
                           input logic [2:0] f64);
      ovr32 = e32; o_imm32 = i32; o_fmt32 = f32;
      ovr64 = e64; o_imm64 = i64; o_fmt64 = f64;
      cycle(1'b1, inst, 4'(inst[10:7]), 1'b1, 1'b0);
      ovr32 = 1'b0;
      ovr64 = 1'b0;
      drain();
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   initial begin
      logic [31:0] inst3;
      logic [15:0] saved;
      bit          got3;

      do_reset();

      send_dir(32'hFFF00093, 1'b1, 32'hFFFFFFFF, 3'd1, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1);
      send_dir(32'h4030D093, 1'b1, 32'h00000003, 3'd6, 1'b1, 64'h3, 3'd6);
      send_dir(32'hFE000CE3, 1'b1, 32'hFFFFFFF8, 3'd3, 1'b1, 64'hFFFFFFFFFFFFFFF8, 3'd3);
      send_dir(32'hFFDFF06F, 1'b1, 32'hFFFFFFFC, 3'd5, 1'b1, 64'hFFFFFFFFFFFFFFFC, 3'd5);
      send_dir(32'h00000000, 1'b1, 32'h0, 3'd0, 1'b1, 64'h0, 3'd0);
      chk("cnt_after_zero", 64'(cnt_a), 64'd1);
      send_dir(32'h300FD0F3, 1'b1, CSR_EN ? 32'd31 : 32'd0, CSR_EN ? 3'd7 : 3'd0,
               1'b1, CSR_EN ? 64'd31 : 64'd0, CSR_EN ? 3'd7 : 3'd0);
      send_dir(32'h80000037, 1'b1, 32'h80000000, 3'd4, 1'b1, 64'hFFFFFFFF80000000, 3'd4);
      send_dir(32'h0000501B, 1'b1, 32'h0, 3'd0, 1'b0, 64'h0, 3'd0);
      send_dir(32'h03F01013, 1'b1, 32'h0000001F, 3'd6, 1'b1, 64'h3F, 3'd6);

      // Backpressure: tags 1,2,3 with the consumer stalled.
      cycle(1'b1, rand_inst(), 4'd1, 1'b0, 1'b0);
      cycle(1'b1, rand_inst(), 4'd2, 1'b0, 1'b0);
      chk("in_ready_fall", 64'(in_ready_a), 64'd0);
      inst3 = rand_inst();
      repeat (4) cycle(1'b1, inst3, 4'd3, 1'b0, 1'b0);
      got3 = 1'b0;
      for (int i = 0; i < 10 && !got3; i++) begin
         cycle(1'b1, inst3, 4'd3, 1'b1, 1'b0);
         got3 = accepted;
      end
      chk("tag3_accepted", 64'(got3), 64'd1);
      drain();

      // Flush with both stages full and an input presented in the same cycle.
      cycle(1'b1, 32'h0, 4'd5, 1'b0, 1'b0);
      cycle(1'b1, 32'h0, 4'd6, 1'b0, 1'b0);
      chk("flush_full", 64'(out_valid_a), 64'd1);
      saved = cnt_a;
      cycle(1'b1, 32'h0, 4'd7, 1'b0, 1'b1);
      chk("flush_out_valid32", 64'(out_valid_a), 64'd0);
      chk("flush_out_valid64", 64'(out_valid_b), 64'd0);
      drain();
      chk("flush_cnt", 64'(cnt_a), 64'(saved));

      // Random traffic with occasional flushes.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(9, 0) < 7, rand_inst(), 4'($urandom()),
               $urandom_range(9, 0) < 7, $urandom_range(39, 0) == 0);
      end
      drain();

      // Reset with entries in flight.
      cycle(1'b1, rand_inst(), 4'd9, 1'b0, 1'b0);
      cycle(1'b1, rand_inst(), 4'd10, 1'b0, 1'b0);
      do_reset();
      drain();

      // Saturate the illegal counter, then push one more illegal result.
      for (int i = 0; i < 65540; i++) cycle(1'b1, 32'h0, 4'(i), 1'b1, 1'b0);
      drain();
      chk("cnt_sat32", 64'(cnt_a), 64'hFFFF);
      chk("cnt_sat64", 64'(cnt_b), 64'hFFFF);
      cycle(1'b1, 32'h0, 4'd1, 1'b1, 1'b0);
      drain();
      chk("cnt_hold32", 64'(cnt_a), 64'hFFFF);
      chk("cnt_hold64", 64'(cnt_b), 64'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried alongside each instruction.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all in-flight entries.
REQ-006 SHALL have port in_valid  input  1  in_inst/in_tag valid.
REQ-007 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-008 SHALL have port in_inst  input  32  RV32/RV64 base instruction word.
REQ-009 SHALL have port in_tag  input  TAG_W  opaque tag, returned unchanged.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_imm  output  XLEN  assembled immediate.
REQ-013 SHALL have port out_fmt  output  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 Z.
REQ-014 SHALL have port out_illegal  output  1  opcode not recognised.
REQ-015 SHALL have port out_tag  output  TAG_W  tag of the result.
REQ-016 SHALL have port illegal_cnt  output  16  count of illegal results delivered.

Function
REQ-017 SHALL be a two-stage pipeline: S1 registers inst, tag and decoded format; S2 registers the assembled immediate, format, illegal flag and tag.
REQ-018 SHALL have latency 2 cycles from an accepted input to out_valid when out_ready stays high, with throughput 1 per cycle.
REQ-019 SHALL define transfer as valid&&ready at either port; each stage SHALL advance when empty or when its downstream transfers; in_ready = !S1_valid || S1 advances.
REQ-020 SHALL hold out_imm/out_fmt/out_tag/out_illegal stable while out_valid && !out_ready; no entry lost, duplicated or reordered.
REQ-021 SHALL decode opcodes: 0000011, 1100111 -> I; 0010011 -> I, except funct3 001/101 -> SHAMT; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; all others -> NONE with out_illegal=1 and out_imm=0.
REQ-022 SHALL, when XLEN=64, also decode 0000011 with funct3 011/110 and opcode 0011011 (I, SHAMT for funct3 001/101); when XLEN=32, 0011011 SHALL be illegal.
REQ-023 SHALL sign-extend I, S, B, U, J immediates from inst[31] to the full XLEN width; B and J bit 0 SHALL be 0; U low 12 bits SHALL be 0.
REQ-024 SHALL zero-extend SHAMT: inst[24:20] when XLEN=32 or opcode 0011011, inst[25:20] when XLEN=64 with opcode 0010011; funct7 bits SHALL NOT appear in out_imm.
REQ-025 SHALL increment illegal_cnt by 1 on each output transfer with out_illegal=1, saturating at 0xFFFF.
REQ-026 SHALL, on flush, clear S1_valid and S2_valid at the next edge; an input presented in the same cycle SHALL be dropped; illegal_cnt SHALL be unaffected by flushed entries.
REQ-027 SHALL give rst priority over flush and over all handshakes.

Reset
REQ-028 SHALL, on rst high at a clock edge, set S1_valid=0, S2_valid=0, out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, illegal_cnt=0.
REQ-029 SHALL drive in_ready=0 while rst is high and in_ready=1 in the first cycle after rst deasserts.
REQ-030 SHALL discard any in-flight entries when rst asserts mid-operation.

Configuration
REQ-031 SHALL, with macro IMM_GEN_CSR_EN defined, decode opcode 1110011 with funct3 101/110/111 as Z: out_imm = zero-extended inst[19:15], out_illegal=0.
REQ-032 SHALL, without IMM_GEN_CSR_EN, treat all 1110011 encodings as illegal (fmt NONE, imm 0).

Verification
REQ-033 SHALL cover: 0xFFF00093 (addi -1), out_ready=1 -> after 2 cycles out_imm=0xFFFFFFFF, out_fmt=1.
REQ-034 SHALL cover: 0x4030D093 (srai 3) -> out_imm=0x00000003, out_fmt=6; 0xFE000CE3 (beq -8) -> 0xFFFFFFF8, fmt 3; 0xFFDFF06F (jal -4) -> 0xFFFFFFFC, fmt 5.
REQ-035 SHALL cover: tags 1,2,3 sent back-to-back with out_ready=0 for 4 cycles -> in_ready falls after the 2nd input; all three delivered in order 1,2,3 with stable outputs.
REQ-036 SHALL cover: 0x00000000 delivered -> out_illegal=1, illegal_cnt=1; with the counter preloaded to 0xFFFF via 65535 illegal deliveries, one more illegal delivery -> count remains 0xFFFF.
REQ-037 SHALL cover: 0x300FD0F3 (csrrwi uimm=31) -> with IMM_GEN_CSR_EN out_imm=31, fmt 7; without it -> out_illegal=1.
REQ-038 SHALL cover: XLEN=64, 0x80000037 (lui) -> out_imm=0xFFFFFFFF80000000; flush asserted with both stages full -> out_valid=0 next cycle, illegal_cnt unchanged.
